wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter.sv | 104 ++++++++++
 tb/tb_wb_arbiter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// Writeback arbiter: grants up to two of NREQ requesters per cycle onto two
// registered register-file write ports, round-robin, never two writes to one register.
module wb_arbiter #(
  parameter int NREQ = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 hold,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [5*NREQ-1:0]    req_reg,
  input  logic [32*NREQ-1:0]   req_data,
  output logic [4:0]           wreg0,
  output logic [31:0]          wdata0,
  output logic                 wen0,
  output logic [4:0]           wreg1,
  output logic [31:0]          wdata1,
  output logic                 wen1,
  output logic [7:0]           busy_cnt
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [PW-1:0] LAST = PW'(NREQ - 1);

  // Handshake: a write moves on requester i in any cycle where req_valid[i] and
  // req_ready[i] are both 1; a requester keeps reg/data stable while valid && !ready.
  logic [4:0]  regs  [NREQ];
  logic [31:0] datas [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign regs[i]  = req_reg[5*i +: 5];
    assign datas[i] = req_data[32*i +: 32];
  end

  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] g0_idx;
  logic [PW-1:0] g1_idx;
  logic          g0_found;
  logic          g1_found;
  logic [PW-1:0] last_idx;
  logic [PW-1:0] next_ptr;
  logic          refused;

  // Circular scan from rr_ptr; the second grant skips a same-register collision.
  always_comb begin
    logic [PW-1:0] idx;
    g0_found = 1'b0;
    g1_found = 1'b0;
    g0_idx   = '0;
    g1_idx   = '0;
    idx      = rr_ptr;
    for (int k = 0; k < NREQ; k++) begin
      if (req_valid[idx] && !hold && !reset) begin
        if (!g0_found) begin
          g0_found = 1'b1;
          g0_idx   = idx;
        end else if (!g1_found &&
                     !((regs[idx] != 5'd0) && (regs[idx] == regs[g0_idx]))) begin
          g1_found = 1'b1;
          g1_idx   = idx;
        end
      end
      idx = (idx == LAST) ? '0 : idx + PW'(1);
    end
  end

  always_comb begin
    req_ready = '0;
    if (g0_found) req_ready[g0_idx] = 1'b1;
    if (g1_found) req_ready[g1_idx] = 1'b1;
  end

  assign last_idx = g1_found ? g1_idx : g0_idx;
  assign next_ptr = (last_idx == LAST) ? '0 : last_idx + PW'(1);
  assign refused  = |(req_valid & ~req_ready);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wen0     <= 1'b0;
      wreg0    <= '0;
      wdata0   <= '0;
      wen1     <= 1'b0;
      wreg1    <= '0;
      wdata1   <= '0;
      rr_ptr   <= '0;
      busy_cnt <= '0;
    end else begin
      // Register x0 is accepted from the requester but never written.
      wen0 <= g0_found && (regs[g0_idx] != 5'd0);
      if (g0_found) begin
        wreg0  <= regs[g0_idx];
        wdata0 <= datas[g0_idx];
      end
      wen1 <= g1_found && (regs[g1_idx] != 5'd0);
      if (g1_found) begin
        wreg1  <= regs[g1_idx];
        wdata1 <= datas[g1_idx];
      end
      if (g0_found) rr_ptr <= next_ptr;
      if (refused && (busy_cnt != 8'hFF)) busy_cnt <= busy_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios then random traffic, all checked
// against a queue-based reference model of the grant rules.
module tb_wb_arbiter;

  localparam int N = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            hold;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [5*N-1:0]  req_reg;
  logic [32*N-1:0] req_data;
  logic [4:0]      wreg0, wreg1;
  logic [31:0]     wdata0, wdata1;
  logic            wen0, wen1;
  logic [7:0]      busy_cnt;

  int checks = 0;
  int errors = 0;

  // clock / reset
  always #5 clk = ~clk;

  wb_arbiter #(.NREQ(N)) dut (
    .clk(clk), .reset(reset), .hold(hold),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_reg(req_reg), .req_data(req_data),
    .wreg0(wreg0), .wdata0(wdata0), .wen0(wen0),
    .wreg1(wreg1), .wdata1(wdata1), .wen1(wen1),
    .busy_cnt(busy_cnt)
  );

  // requester state as seen by the bench
  logic        v [N];
  logic [4:0]  r [N];
  logic [31:0] d [N];

  // reference model state
  int          m_ptr;
  int          m_busy;
  logic        m_wen0, m_wen1;
  logic [4:0]  m_wreg0, m_wreg1;
  logic [31:0] m_wdata0, m_wdata1;
  logic [75:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i]        = v[i];
      req_reg[5*i +: 5]   = r[i];
      req_data[32*i +: 32] = d[i];
    end
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < N; i++) begin
      v[i] = 1'b0;
      r[i] = 5'd0;
      d[i] = 32'd0;
    end
    drive();
  endtask

  task automatic model_reset();
    m_ptr = 0; m_busy = 0;
    m_wen0 = 1'b0; m_wen1 = 1'b0;
    m_wreg0 = '0; m_wreg1 = '0;
    m_wdata0 = '0; m_wdata1 = '0;
    exp_q.delete();
  endtask

  // Grant rule: list valid requesters in circular order from the pointer;
  // first one wins port 0, the next one not colliding on a nonzero register wins port 1.
  function automatic void model_grants(output int g0, output int g1);
    int order[$];
    g0 = -1;
    g1 = -1;
    if (hold || reset) return;
    for (int k = 0; k < N; k++) begin
      if (v[(m_ptr + k) % N]) order.push_back((m_ptr + k) % N);
    end
    if (order.size() == 0) return;
    g0 = order[0];
    for (int j = 1; j < order.size(); j++) begin
      if (!(r[order[j]] != 5'd0 && r[order[j]] == r[g0])) begin
        g1 = order[j];
        break;
      end
    end
  endfunction

  // One clock: check ready mid-cycle, predict, then check registered outputs.
  task automatic cycle(output logic [N-1:0] granted, output logic [N-1:0] obs_ready);
    int g0, g1;
    logic [N-1:0] exp_ready;
    logic [75:0] e;
    logic any_refused;
    @(negedge clk);
    model_grants(g0, g1);
    exp_ready = '0;
    if (g0 >= 0) exp_ready[g0] = 1'b1;
    if (g1 >= 0) exp_ready[g1] = 1'b1;
    obs_ready = req_ready;
    check("req_ready", 32'(req_ready), 32'(exp_ready));
    if (g0 >= 0) begin
      m_wen0 = (r[g0] != 5'd0); m_wreg0 = r[g0]; m_wdata0 = d[g0];
    end else m_wen0 = 1'b0;
    if (g1 >= 0) begin
      m_wen1 = (r[g1] != 5'd0); m_wreg1 = r[g1]; m_wdata1 = d[g1];
    end else m_wen1 = 1'b0;
    if (g1 >= 0) m_ptr = (g1 + 1) % N;
    else if (g0 >= 0) m_ptr = (g0 + 1) % N;
    any_refused = 1'b0;
    for (int i = 0; i < N; i++) if (v[i] && !exp_ready[i]) any_refused = 1'b1;
    if (any_refused && m_busy < 255) m_busy++;
    exp_q.push_back({m_wen0, m_wreg0, m_wdata0, m_wen1, m_wreg1, m_wdata1});
    granted = exp_ready;
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("wen0",   32'(wen0),   32'(e[75]));
    check("wreg0",  32'(wreg0),  32'(e[74:70]));
    check("wdata0", wdata0,      e[69:38]);
    check("wen1",   32'(wen1),   32'(e[37]));
    check("wreg1",  32'(wreg1),  32'(e[36:32]));
    check("wdata1", wdata1,      e[31:0]);
    check("busy_cnt", 32'(busy_cnt), 32'(m_busy));
    check("no_dup_write", 32'(wen0 && wen1 && (wreg0 == wreg1)), 32'd0);
  endtask

  task automatic set_all(input logic [4:0] base);
    for (int i = 0; i < N; i++) begin
      v[i] = 1'b1;
      r[i] = base + 5'(i);
      d[i] = $urandom;
    end
    drive();
  endtask

  // Single x0 write from the last requester parks the pointer at 0.
  task automatic park_ptr();
    logic [N-1:0] gr, obs;
    clear_reqs();
    v[N-1] = 1'b1;
    drive();
    cycle(gr, obs);
    clear_reqs();
  endtask

  initial begin
    logic [N-1:0] gr, obs;
    reset = 1'b1;
    hold  = 1'b0;
    clear_reqs();
    model_reset();

    @(posedge clk);
    #1;
    check("rst_wen0", 32'(wen0), 32'd0);
    check("rst_wen1", 32'(wen1), 32'd0);
    check("rst_wreg0", 32'(wreg0), 32'd0);
    check("rst_wdata1", wdata1, 32'd0);
    check("rst_busy", 32'(busy_cnt), 32'd0);
    v[0] = 1'b1;
    drive();
    check("rst_ready", 32'(req_ready), 32'd0);
    clear_reqs();
    reset = 1'b0;

    // single write
    v[0] = 1'b1; r[0] = 5'd5; d[0] = 32'hDEADBEEF;
    drive();
    cycle(gr, obs);
    check("t028_ready", 32'(obs), 32'b0001);
    check("t028_wen0", 32'(wen0), 32'd1);
    check("t028_wreg0", 32'(wreg0), 32'd5);
    check("t028_wdata0", wdata0, 32'hDEADBEEF);
    check("t028_wen1", 32'(wen1), 32'd0);
    clear_reqs();
    cycle(gr, obs);
    check("t028_pulse", 32'(wen0), 32'd0);

    // four distinct registers, two cycles
    park_ptr();
    set_all(5'd1);
    cycle(gr, obs);
    check("t029_c0", 32'(obs), 32'b0011);
    check("t029_c0_regs", {22'd0, wreg0, wreg1}, {22'd0, 5'd1, 5'd2});
    set_all(5'd1);
    cycle(gr, obs);
    check("t029_c1", 32'(obs), 32'b1100);
    check("t029_c1_regs", {22'd0, wreg0, wreg1}, {22'd0, 5'd3, 5'd4});
    set_all(5'd1);
    cycle(gr, obs);
    check("t029_wrap", 32'(obs), 32'b0011);

    // same-register collision
    park_ptr();
    v[0] = 1'b1; r[0] = 5'd7; d[0] = 32'h0000_0A0A;
    v[1] = 1'b1; r[1] = 5'd7; d[1] = 32'h0000_0B0B;
    v[2] = 1'b1; r[2] = 5'd9; d[2] = 32'h0000_0C0C;
    drive();
    cycle(gr, obs);
    check("t030_ready", 32'(obs), 32'b0101);
    check("t030_w0", {27'd0, wreg0}, 32'd7);
    check("t030_w1", {27'd0, wreg1}, 32'd9);
    v[0] = 1'b0; v[2] = 1'b0;
    drive();
    cycle(gr, obs);
    check("t030_next", 32'(obs), 32'b0010);
    check("t030_next_data", wdata0, 32'h0000_0B0B);
    clear_reqs();

    // write to x0
    v[3] = 1'b1; r[3] = 5'd0; d[3] = 32'h1234;
    drive();
    cycle(gr, obs);
    check("t031_ready", 32'(obs[3]), 32'd1);
    check("t031_wen0", 32'(wen0), 32'd0);
    check("t031_wen1", 32'(wen1), 32'd0);
    clear_reqs();

    // long hold saturates the refusal counter
    hold = 1'b1;
    set_all(5'd10);
    for (int c = 0; c < 300; c++) begin
      cycle(gr, obs);
      if (obs != '0) check("t032_held", 32'(obs), 32'd0);
    end
    check("t032_sat", 32'(busy_cnt), 32'd255);
    hold = 1'b0;
    cycle(gr, obs);
    check("t032_resume", 32'(obs != '0), 32'd1);
    check("t032_sat_hold", 32'(busy_cnt), 32'd255);
    clear_reqs();

    // reset in the middle of a cycle with a write on port 0
    v[1] = 1'b1; r[1] = 5'd11; d[1] = 32'hCAFE_F00D;
    drive();
    cycle(gr, obs);
    check("t033_pre_wen0", 32'(wen0), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("t033_wen0", 32'(wen0), 32'd0);
    check("t033_wen1", 32'(wen1), 32'd0);
    check("t033_busy", 32'(busy_cnt), 32'd0);
    check("t033_wreg0", 32'(wreg0), 32'd0);
    check("t033_ready", 32'(req_ready), 32'd0);
    model_reset();
    set_all(5'd20);
    @(posedge clk);
    #1;
    reset = 1'b0;
    cycle(gr, obs);
    check("t033_first", 32'(obs[0]), 32'd1);
    check("t033_first_reg", 32'(wreg0), 32'd20);

    // random traffic with small register space to force collisions
    clear_reqs();
    gr = '0;
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!v[i] || gr[i]) begin
          v[i] = ($urandom_range(0, 3) != 0);
          r[i] = 5'($urandom_range(0, 6));
          d[i] = $urandom;
        end
      end
      hold = ($urandom_range(0, 7) == 0);
      drive();
      cycle(gr, obs);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
